buzzer_sos_pattern_module: RTL and testbench
============================================

Name: buzzer_sos_pattern_module

Overview:
- Consumer end of the SOS enable pulse. Each accepted one-cycle start pulse on SOS_En_Sig plays one Morse "SOS" (. . .  - - -  . . .) on the buzzer pin, then returns to idle.
- Sits between the periodic SOS enable controller and the board buzzer pin.
- Drives a square-wave tone during the sounding elements and silence during the gaps.

Parameters:
- T_UNIT, 5_000_000: clocks per Morse unit (100 ms at 50 MHz). Minimum 2.
- TONE_HALF, 12_500: clocks per half-period of the tone (2 kHz at 50 MHz). Minimum 1.

Ports:
- CLK  input  1  system clock, 50 MHz.
- RSTn  input  1  asynchronous, active-low reset.
- SOS_En_Sig  input  1  start request, single-cycle pulse from the enable controller.
- Pin_Out  output  1  buzzer drive. Tone while sounding, 0 otherwise.
- Envelope  output  1  high while an element is sounding.
- Busy  output  1  high while a pattern is in progress.
- Done_Sig  output  1  one-cycle pulse when a pattern completes.

Behaviour:
- Reset: every register clears asynchronously. Pin_Out=0, Envelope=0, Busy=0, Done_Sig=0, state=IDLE.
- Element table, 9 entries, index 0..8: lengths 1,1,1,3,3,3,1,1,1 units.
- Gap after each element:
  - 3 units after index 2 and after index 5 (inter-character gaps).
  - 1 unit after every other element except index 8.
  - No gap after index 8.
- Total Busy time is 27*T_UNIT clocks.
- States: IDLE, ON, OFF.
- IDLE:
  - If SOS_En_Sig=1 at a rising edge, go to ON with index=0 and counters cleared.
  - In the next cycle Busy=1 and Envelope=1.
- ON:
  - Lasts len(index)*T_UNIT clocks, counted with a unit counter (0..T_UNIT-1) and a unit tally (0..2).
  - At the end of ON, if index=8: go to IDLE. Done_Sig=1 for exactly one cycle, in the same cycle that Busy falls to 0.
  - Otherwise go to OFF with the gap length taken from the table.
- OFF:
  - Lasts gap*T_UNIT clocks, Envelope=0.
  - Then index increments and the block goes to ON.
- Tone:
  - On every ON entry, the tone counter clears and the tone register is set to 1.
  - The tone register toggles when the tone counter reaches TONE_HALF-1; the counter then wraps to 0.
  - Pin_Out = tone register AND Envelope, registered.
  - Pin_Out is 0 in IDLE and OFF.
- A start pulse while Busy=1 is ignored. It is not queued.
- A start pulse in the same cycle that Done_Sig is asserted (state already IDLE) is accepted.
- If SOS_En_Sig is held high in IDLE, only the first edge counts; the next accept happens after completion.
- Reset mid-pattern aborts immediately. All outputs go to 0 and the next start begins again at index 0.
- Counter widths are sized with $clog2 of the parameters. No counter may overflow at the default values.

Test Plan:
- Use T_UNIT=4, TONE_HALF=2. Reset, then pulse SOS_En_Sig in cycle 0.
  - Envelope high in cycles 1-4, 9-12, 17-20, 33-44, 49-60, 65-76, 89-92, 97-100, 105-108.
  - Busy high in cycles 1-108.
  - Done_Sig=1 in cycle 109 only, with Busy=0 in cycle 109.
- Tone check in the same run: within cycles 1-4, Pin_Out=1,1,0,0. Within cycles 33-44, Pin_Out repeats 1,1,0,0 three times. Pin_Out=0 in every gap.
- Extra SOS_En_Sig pulses at cycles 20 and 70 produce no change to the above waveform. A pulse at cycle 109 restarts the pattern, with Envelope=1 in cycle 110.
- Assert RSTn=0 at cycle 50: all outputs go to 0 in that cycle. Release and pulse start: the full 108-cycle pattern replays from the first dot.
- Hold SOS_En_Sig high for 300 cycles: exactly two complete patterns and two Done_Sig pulses, at cycles 109 and 218.
- With T_UNIT=2 and TONE_HALF=1: Busy lasts 54 cycles and Pin_Out toggles every cycle while Envelope=1.

Source files
------------

// File: rtl/buzzer_sos_pattern_module.sv
// Plays one Morse "SOS" on the buzzer pin for every start pulse accepted in idle.
// A unit counter and a unit tally time each element and gap against a 9-entry table.
module buzzer_sos_pattern_module #(
    parameter int T_UNIT    = 5_000_000,
    parameter int TONE_HALF = 12_500
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic SOS_En_Sig,
    output logic Pin_Out,
    output logic Envelope,
    output logic Busy,
    output logic Done_Sig
);
    localparam int UW = $clog2(T_UNIT);
    localparam int TW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [UW-1:0] U_LAST = UW'(T_UNIT - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TONE_HALF - 1);
    localparam logic [3:0]    IDX_LAST = 4'd8;

    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

    state_t          state, state_nx;
    logic [3:0]      idx, idx_nx;
    logic [UW-1:0]   ucnt, ucnt_nx;
    logic [1:0]      tally, tally_nx;
    logic [TW-1:0]   tcnt, tcnt_nx;
    logic            tone, tone_nx;
    logic            pin, pin_nx;
    logic            done, done_nx;
    logic [1:0]      seg_units;
    logic            seg_end;

    // Dashes sit at indices 3..5; everything else is a one-unit dot.
    function automatic logic [1:0] el_units(input logic [3:0] i);
        return (i >= 4'd3 && i <= 4'd5) ? 2'd3 : 2'd1;
    endfunction

    // Inter-character gaps follow the last dot of S and the last dash of O.
    function automatic logic [1:0] gap_units(input logic [3:0] i);
        return (i == 4'd2 || i == 4'd5) ? 2'd3 : 2'd1;
    endfunction

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            idx   <= '0;
            ucnt  <= '0;
            tally <= '0;
            tcnt  <= '0;
            tone  <= 1'b0;
            pin   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            ucnt  <= ucnt_nx;
            tally <= tally_nx;
            tcnt  <= tcnt_nx;
            tone  <= tone_nx;
            pin   <= pin_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        ucnt_nx   = ucnt;
        tally_nx  = tally;
        done_nx   = 1'b0;
        seg_units = (state == ON) ? el_units(idx) : gap_units(idx);
        seg_end   = (ucnt == U_LAST) && (tally == seg_units - 2'd1);
        case (state)
            IDLE: begin
                if (SOS_En_Sig) begin
                    state_nx = ON;
                    idx_nx   = '0;
                    ucnt_nx  = '0;
                    tally_nx = '0;
                end
            end
            ON, OFF: begin
                if (seg_end) begin
                    ucnt_nx  = '0;
                    tally_nx = '0;
                    if (state == OFF) begin
                        state_nx = ON;
                        idx_nx   = idx + 4'd1;
                    end else if (idx == IDX_LAST) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = OFF;
                    end
                end else if (ucnt == U_LAST) begin
                    ucnt_nx  = '0;
                    tally_nx = tally + 2'd1;
                end else begin
                    ucnt_nx = ucnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Tone phase restarts high on every element so each one begins identically.
    always_comb begin
        tcnt_nx = tcnt;
        tone_nx = tone;
        if (state_nx == ON && state != ON) begin
            tcnt_nx = '0;
            tone_nx = 1'b1;
        end else if (state == ON) begin
            if (tcnt == T_LAST) begin
                tcnt_nx = '0;
                tone_nx = ~tone;
            end else begin
                tcnt_nx = tcnt + 1'b1;
            end
        end
        pin_nx = tone_nx & (state_nx == ON);
    end

    assign Pin_Out  = pin;
    assign Envelope = (state == ON);
    assign Busy     = (state != IDLE);
    assign Done_Sig = done;
endmodule

// File: tb/tb_buzzer_sos_pattern_module.sv
// Bench for the SOS buzzer: a timeline model built from the element/gap table,
// spot-check vectors from the expected waveform, and hand-written corner sequences.
module tb_buzzer_sos_pattern_module;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic pin1, env1, busy1, done1;
    logic pin2, env2, busy2, done2;

    always #5 clk = ~clk;

    buzzer_sos_pattern_module #(.T_UNIT(4), .TONE_HALF(2)) dut (
        .CLK(clk), .RSTn(rstn), .SOS_En_Sig(start),
        .Pin_Out(pin1), .Envelope(env1), .Busy(busy1), .Done_Sig(done1)
    );

    buzzer_sos_pattern_module #(.T_UNIT(2), .TONE_HALF(1)) dut2 (
        .CLK(clk), .RSTn(rstn), .SOS_En_Sig(start),
        .Pin_Out(pin2), .Envelope(env2), .Busy(busy2), .Done_Sig(done2)
    );

    int total = 0;
    int bad = 0;
    bit sel = 1'b0;
    logic stim     [0:599];
    logic obs_env  [0:599];
    logic obs_busy [0:599];
    logic obs_pin  [0:599];
    logic obs_done [0:599];

    typedef struct {
        int   cyc;
        logic env;
        logic busy;
        logic pin;
        logic done;
    } vec_t;

    function automatic logic o_env();  return sel ? env2  : env1;  endfunction
    function automatic logic o_busy(); return sel ? busy2 : busy1; endfunction
    function automatic logic o_pin();  return sel ? pin2  : pin1;  endfunction
    function automatic logic o_done(); return sel ? done2 : done1; endfunction

    task automatic chk(input string name, input int c, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0b want=%0b", name, c, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs k cycles after an accepted start pulse, walking the Morse table.
    task automatic model(input int k, input int t_unit, input int half,
                         output logic env, output logic pin, output logic busy, output logic done);
        int lens [0:8];
        int t;
        lens = '{1, 1, 1, 3, 3, 3, 1, 1, 1};
        env = 0; pin = 0; busy = 0; done = 0;
        if (k == 27 * t_unit + 1) done = 1;
        if (k >= 1 && k <= 27 * t_unit) begin
            busy = 1;
            t = k - 1;
            for (int i = 0; i < 9; i++) begin
                if (t >= 0 && t < lens[i] * t_unit) begin
                    env = 1;
                    pin = ((t / half) % 2) == 0;
                end
                t = t - lens[i] * t_unit;
                t = t - ((i == 2 || i == 5) ? 3 : (i == 8 ? 0 : 1)) * t_unit;
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        start = 1'b0;
        tick();
        tick();
        chk("reset_env", -1, o_env(), 1'b0);
        chk("reset_busy", -1, o_busy(), 1'b0);
        chk("reset_pin", -1, o_pin(), 1'b0);
        chk("reset_done", -1, o_done(), 1'b0);
        rstn = 1'b1;
        tick();
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 600; i++) stim[i] = 1'b0;
    endtask

    // Cycle c: outputs checked against the model, then stim[c] applied before the next edge.
    task automatic run(input int n, input int t_unit, input int half);
        int s;
        logic e, p, b, d;
        s = -100000;
        for (int c = 0; c < n; c++) begin
            model(c - s, t_unit, half, e, p, b, d);
            chk("env", c, o_env(), e);
            chk("busy", c, o_busy(), b);
            chk("pin", c, o_pin(), p);
            chk("done", c, o_done(), d);
            obs_env[c] = o_env(); obs_busy[c] = o_busy();
            obs_pin[c] = o_pin(); obs_done[c] = o_done();
            start = stim[c];
            if (start && !b) s = c;
            tick();
        end
        start = 1'b0;
    endtask

    vec_t vecs [15];
    int cnt, first_d, second_d;

    initial begin
        vecs = '{
            '{0,   1'b0, 1'b0, 1'b0, 1'b0},
            '{1,   1'b1, 1'b1, 1'b1, 1'b0},
            '{2,   1'b1, 1'b1, 1'b1, 1'b0},
            '{3,   1'b1, 1'b1, 1'b0, 1'b0},
            '{4,   1'b1, 1'b1, 1'b0, 1'b0},
            '{5,   1'b0, 1'b1, 1'b0, 1'b0},
            '{9,   1'b1, 1'b1, 1'b1, 1'b0},
            '{21,  1'b0, 1'b1, 1'b0, 1'b0},
            '{33,  1'b1, 1'b1, 1'b1, 1'b0},
            '{37,  1'b1, 1'b1, 1'b1, 1'b0},
            '{44,  1'b1, 1'b1, 1'b0, 1'b0},
            '{45,  1'b0, 1'b1, 1'b0, 1'b0},
            '{108, 1'b1, 1'b1, 1'b0, 1'b0},
            '{109, 1'b0, 1'b0, 1'b0, 1'b1},
            '{110, 1'b1, 1'b1, 1'b1, 1'b0}
        };

        // Main waveform with ignored pulses, restart on the done cycle, then random pulses.
        sel = 1'b0;
        do_reset();
        clear_stim();
        stim[0] = 1; stim[20] = 1; stim[70] = 1; stim[109] = 1;
        for (int c = 230; c < 420; c++) stim[c] = ($urandom_range(0, 14) == 0);
        run(420, 4, 2);
        for (int i = 0; i < 15; i++) begin
            chk("vec_env", vecs[i].cyc, obs_env[vecs[i].cyc], vecs[i].env);
            chk("vec_busy", vecs[i].cyc, obs_busy[vecs[i].cyc], vecs[i].busy);
            chk("vec_pin", vecs[i].cyc, obs_pin[vecs[i].cyc], vecs[i].pin);
            chk("vec_done", vecs[i].cyc, obs_done[vecs[i].cyc], vecs[i].done);
        end

        // Reset mid-pattern aborts at once; the next start replays from the first dot.
        do_reset();
        clear_stim();
        stim[0] = 1;
        run(50, 4, 2);
        rstn = 1'b0;
        #1;
        chk("abort_env", 50, o_env(), 1'b0);
        chk("abort_busy", 50, o_busy(), 1'b0);
        chk("abort_pin", 50, o_pin(), 1'b0);
        chk("abort_done", 50, o_done(), 1'b0);
        do_reset();
        run(112, 4, 2);

        // Start held high for 300 cycles: two complete patterns.
        do_reset();
        clear_stim();
        for (int c = 0; c < 300; c++) stim[c] = 1;
        run(300, 4, 2);
        cnt = 0; first_d = -1; second_d = -1;
        for (int c = 0; c < 300; c++) begin
            if (obs_done[c] === 1'b1) begin
                cnt++;
                if (first_d < 0) first_d = c;
                else if (second_d < 0) second_d = c;
            end
        end
        chk_int("held_done_count", cnt, 2);
        chk_int("held_done_first", first_d, 109);
        chk_int("held_done_second", second_d, 218);

        // Shortest timing: tone toggles every cycle, 54-cycle busy window.
        sel = 1'b1;
        do_reset();
        clear_stim();
        stim[0] = 1;
        run(70, 2, 1);
        cnt = 0;
        for (int c = 0; c < 70; c++) if (obs_busy[c] === 1'b1) cnt++;
        chk_int("short_busy_len", cnt, 54);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
